// File: rtl/edge_pulse_sched.sv
// Rising-edge event capture with per-line saturating pending counters,
// served round-robin to a valid/ready consumer with an enforced idle gap.
module edge_pulse_sched #(
    parameter int N   = 4,
    parameter int CW  = 2,
    parameter int GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         sig,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_ready,
    output logic                 ppulse,
    output logic [N-1:0]         ovf
);

    localparam int          IW = $clog2(N);
    localparam int unsigned NU = N;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   last_q, last_d;
    logic [3:0]      gap_q, gap_d;
    logic [CW-1:0]   pend_q [N];
    logic [CW-1:0]   pend_d [N];
    logic [N-1:0]    ovf_q, ovf_d;
    logic [N-1:0]    sig_q;
    logic [N-1:0]    rise;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;

    assign rise = sig & ~sig_q & {N{en}};

    always_ff @(posedge clk) begin
        sig_q <= sig;
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            last_q  <= IW'(N - 1);
            gap_q   <= '0;
            pend_q  <= '{default: '0};
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    // Round-robin: first nonzero counter starting one past the last accepted line.
    always_comb begin
        logic [IW-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            idx = IW'((32'(last_q) + k) % NU);
            if (!sel_found && pend_q[idx] != '0) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    id_d    = sel_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ppulse) begin
                    last_d = id_q;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 4'(GAP);
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Simultaneous rise and acceptance on one line cancel out.
    always_comb begin
        logic inc, dec;
        ovf_d = ovf_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            pend_d[i] = pend_q[i];
            inc = rise[i];
            dec = ppulse && (id_q == IW'(i));
            if (inc && !dec) begin
                if (pend_q[i] == '1) ovf_d[i] = 1'b1;
                else                 pend_d[i] = pend_q[i] + 1'b1;
            end else if (dec && !inc) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == S_ISSUE);
        out_id    = id_q;
        ppulse    = out_valid & out_ready & ~rst;
        ovf       = ovf_q;
    end

endmodule
